// File: rtl/field_arith_defs.sv
// Field parameters for the prover arithmetic: the Mersenne prime 2^61 - 1.
package field_arith_defs;

    localparam int F_NBITS = 61;
    localparam logic [F_NBITS-1:0] F_Q = {F_NBITS{1'b1}};

endpackage

// File: rtl/prover_compute_v_pkg.sv
// Shared types for the prover V~ sequencers: round-control state encoding
// and the width helper for round indices.
package prover_compute_v_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_TAU   = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_GUARD      = 3'd3,
        ST_BUSY       = 3'd4,
        ST_WAIT_FINAL = 3'd5,
        ST_DONE       = 3'd6
    } rc_state_e;

    localparam int RC_STATE_BITS = 3;

    // Bits needed to hold a round index that can reach n_rounds itself.
    function automatic int round_bits(input int n_rounds);
        return $clog2(n_rounds + 1);
    endfunction

endpackage

// File: rtl/prover_compute_v_oneminus.sv
// Combinational (1 - tau) mod F_Q for a canonical tau.
module prover_compute_v_oneminus
    import field_arith_defs::*;
(
    input  logic [F_NBITS-1:0] tau_i,
    output logic [F_NBITS-1:0] m_tau_p1_o
);

    logic [F_NBITS:0] wide_diff;

    // F_Q + 1 - tau needs one extra bit; tau == 1 would leave F_Q itself,
    // which is non-canonical, so 0 and 1 are handled explicitly.
    always_comb begin
        wide_diff  = {1'b0, F_Q} + {{F_NBITS{1'b0}}, 1'b1} - {1'b0, tau_i};
        m_tau_p1_o = wide_diff[F_NBITS-1:0];
        if (tau_i == '0) begin
            m_tau_p1_o = {{(F_NBITS-1){1'b0}}, 1'b1};
        end else if (tau_i == {{(F_NBITS-1){1'b0}}, 1'b1}) begin
            m_tau_p1_o = '0;
        end
    end

endmodule

// File: rtl/prover_compute_v_roundctl.sv
// Early-round sequencer for the V~ chi bank: takes one challenge tau per
// round, hands tau and (1 - tau) to the bank, waits for the bank to finish
// each round and finally waits for the bank's final result.
//
// Handshake: tau_in is transferred on a cycle where tau_valid and tau_ready
// are both high; tau_ready depends only on state, never on tau_valid.
module prover_compute_v_roundctl
    import field_arith_defs::*;
    import prover_compute_v_pkg::*;
#(
    parameter int nCopyBits  = 3,
    parameter int nRoundBits = round_bits(nCopyBits)
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     start,
    input  logic [F_NBITS-1:0]       tau_in,
    input  logic                     tau_valid,
    output logic                     tau_ready,
    output logic                     bank_en,
    output logic                     bank_restart,
    output logic [F_NBITS-1:0]       tau,
    output logic [F_NBITS-1:0]       m_tau_p1,
    input  logic                     bank_ready,
    input  logic                     bank_final_ready,
    output logic [nRoundBits-1:0]    round,
    output logic                     busy,
    output logic                     done,
    output logic [RC_STATE_BITS-1:0] state_dbg
);

    if (nCopyBits < 1) begin : g_bad_ncopybits
        $error("prover_compute_v_roundctl: nCopyBits must be at least 1");
    end

    localparam logic [nRoundBits-1:0] LAST_ROUND = nRoundBits'(nCopyBits - 1);
    localparam logic [nRoundBits-1:0] ROUND_END  = nRoundBits'(nCopyBits);

    rc_state_e              state_q, state_d;
    logic [nRoundBits-1:0]  round_q, round_d;
    logic [F_NBITS-1:0]     tau_q, tau_d;
    logic [F_NBITS-1:0]     mtp_q, mtp_d;
    logic [F_NBITS-1:0]     mtp_of_tau_in;

    prover_compute_v_oneminus u_oneminus (
        .tau_i      (tau_in),
        .m_tau_p1_o (mtp_of_tau_in)
    );

    // State and datapath registers; reset abandons any round in flight.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            tau_q   <= '0;
            mtp_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            tau_q   <= tau_d;
            mtp_q   <= mtp_d;
        end
    end

    // Next state, round index and latched challenge.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        tau_d   = tau_q;
        mtp_d   = mtp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT_TAU;
                    round_d = '0;
                end
            end
            ST_WAIT_TAU: begin
                if (tau_valid) begin
                    tau_d   = tau_in;
                    mtp_d   = mtp_of_tau_in;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_GUARD;
            end
            // The bank may still show ready from the previous round here.
            ST_GUARD: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (bank_ready) begin
                    if (round_q == LAST_ROUND) begin
                        round_d = ROUND_END;
                        state_d = ST_WAIT_FINAL;
                    end else begin
                        round_d = round_q + 1'b1;
                        state_d = ST_WAIT_TAU;
                    end
                end
            end
            ST_WAIT_FINAL: begin
                if (bank_final_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        tau_ready    = 1'b0;
        bank_en      = 1'b0;
        bank_restart = 1'b0;
        done         = 1'b0;
        busy         = (state_q != ST_IDLE);
        case (state_q)
            ST_WAIT_TAU: tau_ready = 1'b1;
            ST_ISSUE: begin
                bank_en      = 1'b1;
                bank_restart = (round_q == '0);
            end
            ST_DONE:     done = 1'b1;
            default: ;
        endcase
        tau       = tau_q;
        m_tau_p1  = mtp_q;
        round     = round_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_prover_compute_v_roundctl.sv
// Bench for prover_compute_v_roundctl: table of known challenges, a
// randomized run against an arithmetic model of (1 - tau) mod q, and
// hand-written reset / stale-ready / backpressure / ignored-start cases.
module tb_prover_compute_v_roundctl;

  localparam logic [63:0] Q = 64'h1FFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] tau;
    logic [63:0] mtp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstb;
  logic        start;
  logic [60:0] tau_in;
  logic        tau_valid;
  logic        tau_ready;
  logic        bank_en;
  logic        bank_restart;
  logic [60:0] tau;
  logic [60:0] m_tau_p1;
  logic        bank_ready;
  logic        bank_final_ready;
  logic [1:0]  round;
  logic        busy;
  logic        done;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int en_cyc[$];
  logic [63:0] last_tau = '0;
  logic [63:0] last_mtp = '0;
  bit early_final = 0;
  vec_t tbl[6];

  prover_compute_v_roundctl #(.nCopyBits(3)) dut (
    .clk(clk), .rstb(rstb), .start(start), .tau_in(tau_in),
    .tau_valid(tau_valid), .tau_ready(tau_ready), .bank_en(bank_en),
    .bank_restart(bank_restart), .tau(tau), .m_tau_p1(m_tau_p1),
    .bank_ready(bank_ready), .bank_final_ready(bank_final_ready),
    .round(round), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // event monitor
  always @(negedge clk) begin
    if (bank_en) begin
      en_cnt <= en_cnt + 1;
      en_cyc.push_back(cycle);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_mtp(input logic [63:0] t);
    return (Q + 64'd1 - t) % Q;
  endfunction

  function automatic logic [60:0] rand_fe();
    logic [63:0] v;
    v = {$urandom, $urandom} % Q;
    return v[60:0];
  endfunction

  // Entered with the DUT waiting for tau of round r; leaves it after bank completion.
  task automatic do_round(input logic [63:0] t, input logic [63:0] exp_m, input int r,
                          input int pre_wait, input int busy_wait, input bit stale, input bit last);
    chk("wt_ready", tau_ready, 1);
    chk("wt_round", round, r);
    for (int i = 0; i < pre_wait; i++) begin
      tau_valid = 1'b0;
      tau_in = rand_fe();
      step();
      chk("bp_ready", tau_ready, 1);
      chk("bp_en", bank_en, 0);
      chk("bp_tau", tau, last_tau);
      chk("bp_mtp", m_tau_p1, last_mtp);
    end
    tau_valid = 1'b1;
    tau_in = t[60:0];
    step();
    chk("iss_en", bank_en, 1);
    chk("iss_restart", bank_restart, (r == 0));
    chk("iss_tau", tau, t);
    chk("iss_mtp", m_tau_p1, exp_m);
    chk("iss_ready", tau_ready, 0);
    last_tau = t;
    last_mtp = exp_m;
    tau_valid = 1'($urandom_range(0, 1));
    tau_in = rand_fe();
    bank_ready = stale;
    step();
    chk("grd_en", bank_en, 0);
    chk("grd_busy", busy, 1);
    bank_ready = stale;
    step();
    for (int i = 0; i < busy_wait; i++) begin
      bank_ready = 1'b0;
      tau_valid = 1'($urandom_range(0, 1));
      tau_in = rand_fe();
      step();
      chk("bsy_round", round, r);
      chk("bsy_en", bank_en, 0);
      chk("bsy_tau", tau, last_tau);
    end
    bank_ready = 1'b1;
    if (last) bank_final_ready = early_final;
    step();
    bank_ready = 1'b0;
    tau_valid = 1'b0;
    chk("exit_round", round, r + 1);
  endtask

  task automatic do_seq(input vec_t v0, input vec_t v1, input vec_t v2, input int pre_wait,
                        input int busy_wait, input bit stale, input int final_wait, input bit start_on_done);
    int en0;
    int d0;
    en0 = en_cnt;
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("seq_busy", busy, 1);
    do_round(v0.tau, v0.mtp, 0, pre_wait, busy_wait, stale, 0);
    do_round(v1.tau, v1.mtp, 1, pre_wait, busy_wait, stale, 0);
    do_round(v2.tau, v2.mtp, 2, pre_wait, busy_wait, stale, 1);
    chk("wf_round", round, 3);
    chk("wf_ready", tau_ready, 0);
    for (int i = 0; i < final_wait; i++) begin
      bank_final_ready = 1'b0;
      step();
      chk("wf_done", done, 0);
    end
    bank_final_ready = 1'b1;
    step();
    chk("done_pulse", done, 1);
    chk("done_round", round, 3);
    bank_final_ready = 1'b0;
    start = start_on_done;
    step();
    start = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("en_count", en_cnt - en0, 3);
    chk("done_count", done_cnt - d0, 1);
  endtask

  function automatic vec_t mk(input logic [63:0] t);
    vec_t v;
    v.tau = t;
    v.mtp = model_mtp(t);
    return v;
  endfunction

  function automatic logic [63:0] pick_tau();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return Q - 64'd1;
      default: return {3'b0, rand_fe()};
    endcase
  endfunction

  initial begin
    logic [2:0] st_before;
    tbl[0] = '{64'd5, 64'h1FFF_FFFF_FFFF_FFFB};
    tbl[1] = '{64'd0, 64'd1};
    tbl[2] = '{64'd1, 64'd0};
    tbl[3] = '{64'h1FFF_FFFF_FFFF_FFFE, 64'd2};
    tbl[4] = '{64'd2, 64'h1FFF_FFFF_FFFF_FFFE};
    tbl[5] = '{64'd3, 64'h1FFF_FFFF_FFFF_FFFD};

    rstb = 1'b1; start = 1'b0; tau_in = '0; tau_valid = 1'b0;
    bank_ready = 1'b0; bank_final_ready = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_tau", tau, 0);
    chk("rst_mtp", m_tau_p1, 0);
    chk("rst_round", round, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", tau_ready, 0);
    chk("rst_en", bank_en, 0);
    rstb = 1'b0;
    step();

    // table: known challenges, with one 10-cycle backpressure sequence
    do_seq(tbl[0], tbl[1], tbl[2], 0, 1, 0, 2, 0);
    do_seq(tbl[3], tbl[4], tbl[5], 10, 0, 0, 0, 1);

    // stale ready held high with tau_valid always available: 4-cycle spacing
    en_cyc.delete();
    do_seq(tbl[5], tbl[0], tbl[3], 0, 0, 1, 1, 0);
    chk("space_n", en_cyc.size(), 3);
    if (en_cyc.size() == 3) begin
      chk("space_01", en_cyc[1] - en_cyc[0], 4);
      chk("space_12", en_cyc[2] - en_cyc[1], 4);
    end

    // final_ready already high when the last round completes
    early_final = 1;
    do_seq(tbl[2], tbl[4], tbl[1], 0, 0, 1, 0, 1);
    early_final = 0;

    // ignored start in round-1 BUSY, then reset mid-BUSY
    start = 1'b1; step(); start = 1'b0;
    do_round(64'd7, model_mtp(64'd7), 0, 0, 0, 0, 0);
    tau_valid = 1'b1; tau_in = 61'd9; step();
    tau_valid = 1'b0; step();
    step();
    st_before = state_dbg;
    start = 1'b1; step(); start = 1'b0;
    chk("ign_round", round, 1);
    chk("ign_state", state_dbg, st_before);
    chk("ign_en", bank_en, 0);
    chk("ign_tau", tau, 9);
    #2 rstb = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_tau", tau, 0);
    chk("mid_mtp", m_tau_p1, 0);
    chk("mid_round", round, 0);
    chk("mid_done", done, 0);
    step();
    rstb = 1'b0;
    last_tau = '0;
    last_mtp = '0;
    step();
    chk("post_rst_done_cnt", done_cnt, 4);
    do_seq(tbl[1], tbl[2], tbl[0], 1, 2, 0, 1, 0);

    // randomized sequences against the arithmetic model
    for (int s = 0; s < 12; s++) begin
      early_final = 1'($urandom_range(0, 1));
      do_seq(mk(pick_tau()), mk(pick_tau()), mk(pick_tau()),
             $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
             early_final ? 0 : $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) step();
    end
    early_final = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
